// File: rtl/hazard_sequencer.sv
// hazard_sequencer: ID-stage hazard controller for the 5-stage MIPS pipeline.
// Generates PC / IF/ID write enables, ID/EX bubble, IF/ID flush and the
// freeze hold. Sequences two-cycle branch-after-load stalls and counts
// stall and flush events with saturating counters.
module hazard_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             freeze,
    input  logic [5:0]       id_opc,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_taken,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [4:0]       ex_dst,
    input  logic             mem_memread,
    input  logic [4:0]       mem_dst,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL2 = 2'd1,
        FRZ    = 2'd2
    } state_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    state_t state_q, state_d;
    state_t ret_q, ret_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic   br, uses_rt;
    logic   m_ex, m_mem;
    logic   lu, ba, bm, hz;
    logic   stall_cyc;
    state_t eff_state;

    // Decode the ID instruction and detect operand hazards against EX and MEM.
    always_comb begin
        br      = (id_opc == OPC_BEQ) || (id_opc == OPC_BNE);
        uses_rt = (id_opc == OPC_RTYPE) || br || (id_opc == OPC_SW);
        m_ex    = (ex_dst != 5'd0) &&
                  ((ex_dst == id_rs) || (uses_rt && (ex_dst == id_rt)));
        m_mem   = (mem_dst != 5'd0) &&
                  ((mem_dst == id_rs) || (uses_rt && (mem_dst == id_rt)));
        lu      = ex_memread && m_ex;
        ba      = br && ex_regwrite && !ex_memread && m_ex;
        bm      = br && mem_memread && m_mem;
        hz      = lu || ba || bm;
    end

    // Next-state and per-cycle control outputs; FRZ resumes as its saved
    // return state in the same cycle freeze drops.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_hold   = 1'b0;
        stall_cyc   = 1'b0;
        eff_state   = (state_q == FRZ) ? ret_q : state_q;

        if (freeze) begin
            pipe_hold  = 1'b1;
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            state_d    = FRZ;
            ret_d      = eff_state;
        end else begin
            case (eff_state)
                STALL2: begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    stall_cyc   = 1'b1;
                    state_d     = RUN;
                end
                default: begin
                    if (hz) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        stall_cyc   = 1'b1;
                        state_d     = (lu && br) ? STALL2 : RUN;
                    end else begin
                        ifid_flush = id_taken;
                        state_d    = RUN;
                    end
                end
            endcase
        end
    end

    // Saturating event counters; freeze cycles never stall nor flush.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_cyc && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (ifid_flush && (flush_cnt_q != {CNT_W{1'b1}}))
            flush_cnt_d = flush_cnt_q + 1'b1;
    end

    // State, return state and counters with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer (2-bit counters to reach saturation).
module tb_hazard_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       freeze;
    logic [5:0] id_opc;
    logic [4:0] id_rs, id_rt;
    logic       id_taken;
    logic       ex_memread, ex_regwrite;
    logic [4:0] ex_dst;
    logic       mem_memread;
    logic [4:0] mem_dst;
    logic       pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold;
    logic [1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_sequencer #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .id_opc(id_opc), .id_rs(id_rs), .id_rt(id_rt), .id_taken(id_taken),
        .ex_memread(ex_memread), .ex_regwrite(ex_regwrite), .ex_dst(ex_dst),
        .mem_memread(mem_memread), .mem_dst(mem_dst),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_hold(pipe_hold),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        freeze = 0; id_opc = 6'b000000; id_rs = 0; id_rt = 0; id_taken = 0;
        ex_memread = 0; ex_regwrite = 0; ex_dst = 0; mem_memread = 0; mem_dst = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 0;
        step();
        rst = 1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL reset_pc_write got %0b exp 1", pc_write); end
        checks++; if (pipe_hold !== 1'b0 || idex_bubble !== 1'b0 || ifid_flush !== 1'b0) begin errors++; $display("FAIL reset_ctrl got hold=%0b bub=%0b fl=%0b exp 000", pipe_hold, idex_bubble, ifid_flush); end
        checks++; if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1; ex_dst = 8; id_opc = 6'b000000; id_rs = 8; #1;
        checks++; if ({pc_write, ifid_write, idex_bubble, ifid_flush} !== 4'b0010) begin errors++; $display("FAIL lu_stall got %b exp 0010", {pc_write, ifid_write, idex_bubble, ifid_flush}); end
        step();
        ex_memread = 0; #1;
        checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL lu_release got pc=%0b bub=%0b exp 1/0", pc_write, idex_bubble); end
        checks++; if (stall_cnt !== 2'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
    endtask

    task automatic test_branch_load();
        do_reset();
        ex_memread = 1; ex_dst = 9; id_opc = 6'b000100; id_rt = 9; #1;
        checks++; if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin errors++; $display("FAIL bl_stall1 got pc=%0b bub=%0b exp 0/1", pc_write, idex_bubble); end
        step();
        idle(); #1;
        checks++; if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin errors++; $display("FAIL bl_stall2 got pc=%0b bub=%0b exp 0/1", pc_write, idex_bubble); end
        step();
        checks++; if (stall_cnt !== 2'd2) begin errors++; $display("FAIL bl_cnt got %0d exp 2", stall_cnt); end
        id_taken = 1; #1;
        checks++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL bl_flush got fl=%0b pc=%0b exp 1/1", ifid_flush, pc_write); end
        step();
        checks++; if (flush_cnt !== 2'd1) begin errors++; $display("FAIL bl_flush_cnt got %0d exp 1", flush_cnt); end
    endtask

    task automatic test_branch_alu();
        do_reset();
        ex_regwrite = 1; ex_dst = 3; id_opc = 6'b000101; id_rs = 3; id_taken = 1; #1;
        checks++; if ({pc_write, idex_bubble, ifid_flush} !== 3'b010) begin errors++; $display("FAIL ba_stall got %b exp 010", {pc_write, idex_bubble, ifid_flush}); end
        step();
        ex_regwrite = 0; #1;
        checks++; if (ifid_flush !== 1'b1 || pc_write !== 1'b1) begin errors++; $display("FAIL ba_flush got fl=%0b pc=%0b exp 1/1", ifid_flush, pc_write); end
        step();
        checks++; if (stall_cnt !== 2'd1 || flush_cnt !== 2'd1) begin errors++; $display("FAIL ba_cnt got %0d/%0d exp 1/1", stall_cnt, flush_cnt); end
        idle();
        mem_memread = 1; mem_dst = 4; id_opc = 6'b000100; id_rs = 4; #1;
        checks++; if (pc_write !== 1'b0 || idex_bubble !== 1'b1) begin errors++; $display("FAIL bm_stall got pc=%0b bub=%0b exp 0/1", pc_write, idex_bubble); end
        id_opc = 6'b000000; #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL bm_nonbranch got pc=%0b exp 1", pc_write); end
        idle(); #1;
    endtask

    task automatic test_zero_nort();
        do_reset();
        ex_memread = 1; ex_dst = 0; id_rs = 0; id_opc = 6'b000000; #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL zero_reg got pc=%0b exp 1", pc_write); end
        ex_dst = 5; id_opc = 6'b100011; id_rt = 5; id_rs = 2; #1;
        checks++; if (pc_write !== 1'b1) begin errors++; $display("FAIL lw_no_rt got pc=%0b exp 1", pc_write); end
        id_opc = 6'b101011; #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL sw_rt got pc=%0b exp 0", pc_write); end
        idle(); #1;
    endtask

    task automatic test_freeze_stall2();
        do_reset();
        ex_memread = 1; ex_dst = 9; id_opc = 6'b000100; id_rt = 9;
        step();
        idle();
        freeze = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({pipe_hold, pc_write, ifid_write, idex_bubble} !== 4'b1000) begin errors++; $display("FAIL frz_cyc%0d got %b exp 1000", i, {pipe_hold, pc_write, ifid_write, idex_bubble}); end
            step();
        end
        checks++; if (stall_cnt !== 2'd1) begin errors++; $display("FAIL frz_cnt got %0d exp 1", stall_cnt); end
        freeze = 0; #1;
        checks++; if ({pipe_hold, pc_write, idex_bubble} !== 3'b001) begin errors++; $display("FAIL frz_resume got %b exp 001", {pipe_hold, pc_write, idex_bubble}); end
        step();
        checks++; if (stall_cnt !== 2'd2) begin errors++; $display("FAIL frz_resume_cnt got %0d exp 2", stall_cnt); end
        checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL frz_run got pc=%0b bub=%0b exp 1/0", pc_write, idex_bubble); end
        freeze = 1; id_taken = 1; ex_memread = 1; ex_dst = 7; id_rs = 7; #1;
        checks++; if (ifid_flush !== 1'b0 || idex_bubble !== 1'b0 || pipe_hold !== 1'b1) begin errors++; $display("FAIL frz_prio got fl=%0b bub=%0b hold=%0b exp 0/0/1", ifid_flush, idex_bubble, pipe_hold); end
        step();
        checks++; if (stall_cnt !== 2'd2 || flush_cnt !== 2'd0) begin errors++; $display("FAIL frz_prio_cnt got %0d/%0d exp 2/0", stall_cnt, flush_cnt); end
        idle();
        step();
    endtask

    task automatic test_saturation_reset();
        do_reset();
        ex_memread = 1; ex_dst = 8; id_rs = 8;
        for (int i = 0; i < 5; i++) step();
        checks++; if (stall_cnt !== 2'd3) begin errors++; $display("FAIL sat_cnt got %0d exp 3", stall_cnt); end
        idle();
        ex_memread = 1; ex_dst = 9; id_opc = 6'b000100; id_rt = 9;
        step();
        idle(); #1;
        checks++; if (pc_write !== 1'b0) begin errors++; $display("FAIL sat_in_stall2 got pc=%0b exp 0", pc_write); end
        rst = 0;
        step();
        rst = 1; #1;
        checks++; if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin errors++; $display("FAIL rst_abort got pc=%0b bub=%0b exp 1/0", pc_write, idex_bubble); end
        checks++; if (stall_cnt !== 2'd0 || flush_cnt !== 2'd0) begin errors++; $display("FAIL rst_abort_cnt got %0d/%0d exp 0/0", stall_cnt, flush_cnt); end
    endtask

    initial begin
        idle();
        rst = 0;
        #2;
        test_reset();
        test_load_use();
        test_branch_load();
        test_branch_alu();
        test_zero_nort();
        test_freeze_stall2();
        test_saturation_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
